mac_seq_ctrl: RTL and testbench



---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_seq_ctrl_if.sv | 40 ++++
 rtl/MAC_nbit.sv | 35 +++
 rtl/mac_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing controller and MAC datapath wrappers.
// - mac_seq_state_t : controller state encoding
// - MAC_PIPE_DEPTH  : register stages in MAC_nbit (product reg + accumulator reg)
// - CLEAR_CYCLES    : cycles the accumulator clear is held before streaming
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mac_seq_state_t;

  localparam int unsigned MAC_PIPE_DEPTH = 2;
  localparam int unsigned CLEAR_CYCLES   = 1;

  // Width of the shared CLEAR/DRAIN phase counter; must hold
  // max(MAC_PIPE_DEPTH, CLEAR_CYCLES) - 1.
  localparam int unsigned PHASE_W = 4;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of job, operand-stream, MAC-side and result signals for mac_seq_ctrl.
// slave  : the controller (mac_seq_ctrl)
// master : the environment (operand source, MAC instance, result consumer)
// Signals:
//   start/len/busy                 job request and status
//   in_valid/in_ready/a_in/b_in    operand stream handshake
//   mac_a/mac_b/mac_rst_n/mac_out  connection to MAC_nbit
//   res_valid/res_ready/result     result handshake
interface mac_seq_ctrl_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned LEN_W     = 8
);

  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIDTH-1:0]     mac_a;
  logic [WIDTH-1:0]     mac_b;
  logic                 mac_rst_n;
  logic [OUT_WIDTH-1:0] mac_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_WIDTH-1:0] result;

  modport slave (
    input  start, len, in_valid, a_in, b_in, mac_out, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_rst_n, res_valid, result
  );

  modport master (
    output start, len, in_valid, a_in, b_in, mac_out, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_rst_n, res_valid, result
  );

endinterface

// File: rtl/MAC_nbit.sv
// Two-stage unsigned multiply-accumulate datapath.
// Stage 1 registers A*B, stage 2 adds the registered product into the
// accumulator (wrapping modulo 2^OUT_WIDTH).
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-low clear of both registers
//   A, B in   WIDTH-bit unsigned operands
//   out  out  OUT_WIDTH-bit accumulator value
module MAC_nbit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [OUT_WIDTH-1:0] out
);

  logic [2*WIDTH-1:0]   prod_q;
  logic [OUT_WIDTH-1:0] acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
      acc_q  <= acc_q + OUT_WIDTH'(prod_q);
    end
  end

  assign out = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for MAC_nbit dot-product jobs.
// Accepts a job of len operand pairs, clears the MAC accumulator, streams
// the pairs under valid/ready, waits out the MAC pipeline and holds the
// final accumulator value until the consumer accepts it.
// Ports:
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave side of mac_seq_ctrl_if (job, operand, MAC and result signals)
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned LEN_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  mac_seq_ctrl_if.slave   bus
);

  localparam logic [PHASE_W-1:0] CLEAR_LAST = PHASE_W'(CLEAR_CYCLES - 1);
  localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(MAC_PIPE_DEPTH - 1);

  mac_seq_state_t       state_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     beat_cnt_q;
  logic [LEN_W-1:0]     beat_cnt_next;
  logic [PHASE_W-1:0]   phase_cnt_q;
  logic                 busy_q;
  logic                 in_ready_q;
  logic                 res_valid_q;
  logic                 mac_rst_n_q;
  logic [OUT_WIDTH-1:0] result_q;
  logic                 beat;

  assign beat          = bus.in_valid && in_ready_q;
  assign beat_cnt_next = beat_cnt_q + LEN_W'(1);

  // Operands reach the MAC only on an accepted beat; stalls, CLEAR and
  // DRAIN feed zero products so the accumulator is unaffected.
  assign bus.mac_a = beat ? bus.a_in : '0;
  assign bus.mac_b = beat ? bus.b_in : '0;

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.mac_rst_n = mac_rst_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      phase_cnt_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      mac_rst_n_q <= 1'b0;
      result_q    <= '0;
    end else begin
      // Clear is asserted only while entering or staying in CLEAR.
      mac_rst_n_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_q       <= bus.len;
            beat_cnt_q  <= '0;
            phase_cnt_q <= '0;
            busy_q      <= 1'b1;
            mac_rst_n_q <= 1'b0;
            state_q     <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          if (phase_cnt_q == CLEAR_LAST) begin
            phase_cnt_q <= '0;
            if (len_q == '0) begin
              state_q <= ST_DRAIN;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_RUN;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
            mac_rst_n_q <= 1'b0;
          end
        end

        ST_RUN: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_next;
            if (beat_cnt_next == len_q) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // The last product lands in the accumulator after MAC_PIPE_DEPTH
          // edges, so mac_out is final on the drain exit edge.
          if (phase_cnt_q == DRAIN_LAST) begin
            phase_cnt_q <= '0;
            result_q    <= bus.mac_out;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
          end
        end

        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       res_ready;

  int n_checks;
  int n_pass;

  logic [31:0] sb32[$];
  logic [15:0] sb16[$];

  mac_seq_ctrl_if #(.WIDTH(8), .OUT_WIDTH(32), .LEN_W(8)) bus32 ();
  mac_seq_ctrl_if #(.WIDTH(8), .OUT_WIDTH(16), .LEN_W(8)) bus16 ();

  assign bus32.start     = start;
  assign bus32.len       = len;
  assign bus32.in_valid  = in_valid;
  assign bus32.a_in      = a_in;
  assign bus32.b_in      = b_in;
  assign bus32.res_ready = res_ready;
  assign bus16.start     = start;
  assign bus16.len       = len;
  assign bus16.in_valid  = in_valid;
  assign bus16.a_in      = a_in;
  assign bus16.b_in      = b_in;
  assign bus16.res_ready = res_ready;

  mac_seq_ctrl #(.WIDTH(8), .OUT_WIDTH(32), .LEN_W(8)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  MAC_nbit #(.WIDTH(8), .OUT_WIDTH(32)) u_mac32 (
    .clk (clk),
    .rst (bus32.mac_rst_n),
    .A   (bus32.mac_a),
    .B   (bus32.mac_b),
    .out (bus32.mac_out)
  );

  mac_seq_ctrl #(.WIDTH(8), .OUT_WIDTH(16), .LEN_W(8)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  MAC_nbit #(.WIDTH(8), .OUT_WIDTH(16)) u_mac16 (
    .clk (clk),
    .rst (bus16.mac_rst_n),
    .A   (bus16.mac_a),
    .B   (bus16.mac_b),
    .out (bus16.mac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches a job in the current cycle (cycle 0) and streams pairs until
  // res_valid is seen. Expected results go to the scoreboards at launch.
  task automatic do_job(input int n, input logic [7:0] av[8], input logic [7:0] bv[8],
                        input int gap, input bit poke_start,
                        output int beats, output int rv_cyc, output int rdy_first,
                        output int rdy_last, output int rdy_cnt, output int gate_err,
                        output int clr_lo, output int busy_lo, output bit tmo);
    logic [31:0] e32;
    int idx;
    int wait_gap;
    int c;
    e32 = '0;
    for (int i = 0; i < n; i++) e32 = e32 + 32'(av[i]) * 32'(bv[i]);
    sb32.push_back(e32);
    sb16.push_back(e32[15:0]);
    beats = 0; rv_cyc = -1; rdy_first = -1; rdy_last = -1; rdy_cnt = 0;
    gate_err = 0; clr_lo = 0; busy_lo = 0; tmo = 1'b0; idx = 0; wait_gap = 0;
    start = 1'b1;
    len = 8'(n);
    in_valid = 1'b0;
    tick();
    c = 1;
    start = 1'b0;
    while (1) begin
      if (bus32.res_valid === 1'b1) begin
        rv_cyc = c;
        break;
      end
      if (c > 400) begin
        tmo = 1'b1;
        break;
      end
      if (bus32.in_ready === 1'b1) begin
        if (rdy_first < 0) rdy_first = c;
        rdy_last = c;
        rdy_cnt++;
      end
      if (bus32.mac_rst_n !== 1'b1) clr_lo++;
      if (bus32.busy !== 1'b1) busy_lo++;
      if (poke_start && c >= 2) begin
        start = 1'b1;
        len = 8'd7;
      end
      if (idx < n && wait_gap == 0) begin
        in_valid = 1'b1;
        a_in = av[idx];
        b_in = bv[idx];
      end else begin
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
      end
      #1;
      if (in_valid && bus32.in_ready === 1'b1) begin
        beats++;
        idx++;
        wait_gap = gap;
        if (bus32.mac_a !== a_in || bus32.mac_b !== b_in) gate_err++;
      end else begin
        if (bus32.in_ready === 1'b1 && wait_gap > 0) wait_gap--;
        if (bus32.mac_a !== 8'd0 || bus32.mac_b !== 8'd0) gate_err++;
      end
      tick();
      c++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.in_ready !== 1'b0 || bus32.res_valid !== 1'b0)
      $display("FAIL reset_status: busy=%b in_ready=%b res_valid=%b required 0 0 0",
               bus32.busy, bus32.in_ready, bus32.res_valid);
    else n_pass++;
    n_checks++;
    if (bus32.result !== 32'd0 || bus32.mac_rst_n !== 1'b0)
      $display("FAIL reset_result: result=%0d mac_rst_n=%b required 0 0", bus32.result, bus32.mac_rst_n);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus32.mac_rst_n !== 1'b1 || bus32.busy !== 1'b0)
      $display("FAIL reset_release: mac_rst_n=%b busy=%b required 1 0", bus32.mac_rst_n, bus32.busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    av = '{8'd2, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(3, av, bv, 0, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0) $display("FAIL basic_timeout: res_valid never seen"); else n_pass++;
    n_checks++;
    if (bus32.result !== e32) $display("FAIL basic_result: got %0d required %0d", bus32.result, e32); else n_pass++;
    n_checks++;
    if (bus32.result !== 32'd33) $display("FAIL basic_result_const: got %0d required 33", bus32.result); else n_pass++;
    n_checks++;
    if (bus16.result !== e16) $display("FAIL basic_result16: got %0d required %0d", bus16.result, e16); else n_pass++;
    n_checks++;
    if (rv !== 7) $display("FAIL basic_latency: res_valid cycle %0d required 7", rv); else n_pass++;
    n_checks++;
    if (rf !== 2 || rl !== 4 || rc !== 3)
      $display("FAIL basic_in_ready: first=%0d last=%0d count=%0d required 2 4 3", rf, rl, rc);
    else n_pass++;
    n_checks++;
    if (beats !== 3 || ge !== 0) $display("FAIL basic_beats: beats=%0d gate_err=%0d required 3 0", beats, ge); else n_pass++;
    n_checks++;
    if (cl !== 1 || bl !== 0) $display("FAIL basic_clear: clear_cycles=%0d busy_low=%0d required 1 0", cl, bl); else n_pass++;
    accept();
    n_checks++;
    if (bus32.res_valid !== 1'b0 || bus32.busy !== 1'b0)
      $display("FAIL basic_accept: res_valid=%b busy=%b required 0 0", bus32.res_valid, bus32.busy);
    else n_pass++;
  endtask

  task automatic test_stalls();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    av = '{8'd2, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(3, av, bv, 2, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0) $display("FAIL stall_timeout: res_valid never seen"); else n_pass++;
    n_checks++;
    if (bus32.result !== e32 || bus16.result !== e16)
      $display("FAIL stall_result: got %0d/%0d required %0d/%0d", bus32.result, bus16.result, e32, e16);
    else n_pass++;
    n_checks++;
    if (beats !== 3 || ge !== 0) $display("FAIL stall_beats: beats=%0d gate_err=%0d required 3 0", beats, ge); else n_pass++;
    n_checks++;
    if (rv !== 11 || rc !== 7) $display("FAIL stall_timing: res_valid cycle %0d ready cycles %0d required 11 7", rv, rc); else n_pass++;
    accept();
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    av = '{8'd10, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd10, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(2, av, bv, 0, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0 || rv !== 6) $display("FAIL b2b_latency: tmo=%b res_valid cycle %0d required 0 6", tmo, rv); else n_pass++;
    n_checks++;
    if (bus32.result !== e32 || bus16.result !== e16)
      $display("FAIL b2b_result: got %0d/%0d required %0d/%0d", bus32.result, bus16.result, e32, e16);
    else n_pass++;
    accept();
    // Zero-length job launched in the first IDLE cycle, with res_ready held high throughout.
    res_ready = 1'b1;
    do_job(0, av, bv, 0, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0 || rv !== 4) $display("FAIL len0_latency: tmo=%b res_valid cycle %0d required 0 4", tmo, rv); else n_pass++;
    n_checks++;
    if (bus32.result !== e32 || bus16.result !== e16)
      $display("FAIL len0_result: got %0d/%0d required %0d/%0d", bus32.result, bus16.result, e32, e16);
    else n_pass++;
    n_checks++;
    if (rc !== 0 || beats !== 0 || ge !== 0)
      $display("FAIL len0_no_beats: ready cycles=%0d beats=%0d gate_err=%0d required 0 0 0", rc, beats, ge);
    else n_pass++;
    tick();
    res_ready = 1'b0;
    n_checks++;
    if (bus32.res_valid !== 1'b0 || bus32.busy !== 1'b0)
      $display("FAIL len0_min_valid: res_valid=%b busy=%b required 0 0", bus32.res_valid, bus32.busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    av = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(2, av, bv, 0, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0) $display("FAIL wrap_timeout: res_valid never seen"); else n_pass++;
    n_checks++;
    if (bus16.result !== e16 || bus16.result !== 16'd64514)
      $display("FAIL wrap_result16: got %0d required %0d", bus16.result, e16);
    else n_pass++;
    n_checks++;
    if (bus32.result !== e32) $display("FAIL wrap_result32: got %0d required %0d", bus32.result, e32); else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    av = '{8'd9, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd9, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(2, av, bv, 1, 1'b1, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0 || rv !== 7) $display("FAIL bp_latency: tmo=%b res_valid cycle %0d required 0 7", tmo, rv); else n_pass++;
    n_checks++;
    if (bus32.result !== e32 || bus16.result !== e16)
      $display("FAIL bp_result: got %0d/%0d required %0d/%0d", bus32.result, bus16.result, e32, e16);
    else n_pass++;
    n_checks++;
    if (beats !== 2) $display("FAIL bp_beats: beats=%0d required 2", beats); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = 8'd5;
      tick();
      n_checks++;
      if (bus32.res_valid !== 1'b1 || bus32.result !== e32)
        $display("FAIL bp_hold: cycle %0d res_valid=%b result=%0d required 1 %0d", i, bus32.res_valid, bus32.result, e32);
      else n_pass++;
    end
    start = 1'b0;
    accept();
    tick();
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.res_valid !== 1'b0)
      $display("FAIL bp_no_new_job: busy=%b res_valid=%b required 0 0", bus32.busy, bus32.res_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] av[8];
    logic [7:0] bv[8];
    logic [31:0] e32;
    logic [15:0] e16;
    int beats, rv, rf, rl, rc, ge, cl, bl;
    bit tmo;
    start = 1'b1;
    len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    a_in = 8'd7;
    b_in = 8'd7;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.in_ready !== 1'b0 || bus32.res_valid !== 1'b0 || bus32.mac_rst_n !== 1'b0)
      $display("FAIL midrst_status: busy=%b in_ready=%b res_valid=%b mac_rst_n=%b required 0 0 0 0",
               bus32.busy, bus32.in_ready, bus32.res_valid, bus32.mac_rst_n);
    else n_pass++;
    n_checks++;
    if (bus32.result !== 32'd0 || bus16.result !== 16'd0)
      $display("FAIL midrst_result: got %0d/%0d required 0/0", bus32.result, bus16.result);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus32.mac_rst_n !== 1'b1 || bus32.busy !== 1'b0)
      $display("FAIL midrst_release: mac_rst_n=%b busy=%b required 1 0", bus32.mac_rst_n, bus32.busy);
    else n_pass++;
    av = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bv = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_job(1, av, bv, 0, 1'b0, beats, rv, rf, rl, rc, ge, cl, bl, tmo);
    e32 = sb32.pop_front();
    e16 = sb16.pop_front();
    n_checks++;
    if (tmo !== 1'b0 || rv !== 5) $display("FAIL fresh_latency: tmo=%b res_valid cycle %0d required 0 5", tmo, rv); else n_pass++;
    n_checks++;
    if (bus32.result !== e32 || bus16.result !== e16 || bus32.result !== 32'd9)
      $display("FAIL fresh_result: got %0d/%0d required %0d/%0d", bus32.result, bus16.result, e32, e16);
    else n_pass++;
    accept();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_stalls();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
